// File: rtl/i2c_master_ctrl_if.sv
// User-side request/response bundle for the single-byte I2C initiator.
// master drives the request fields; slave is the controller that answers them.
interface i2c_master_ctrl_if;
    // start is honoured only while busy=0 and done may be high; the request fields
    // are captured on that same edge. done pulses once per accepted start, ok or not,
    // and rdata/ack_err stay valid from done until the next accepted start.
    logic       start;
    logic       rw;
    logic [6:0] slave_addr;
    logic [7:0] mem_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        output start, rw, slave_addr, mem_addr, wdata,
        input  rdata, busy, done, ack_err
    );

    modport slave (
        input  start, rw, slave_addr, mem_addr, wdata,
        output rdata, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C initiator: START, {addr,rw}, mem_addr, one data byte, STOP.
// Every bit is four quarters of CLK_DIV clocks; SDA is sampled on the last clock of Q3.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    i2c_master_ctrl_if.slave ctrl,
    output logic             scl,
    inout  wire              sda,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_MEM, S_ACK_M,
        S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_STOP
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] qdiv;
    logic [1:0]       q;
    logic [2:0]       bit_cnt;
    logic             rw_q;
    logic [6:0]       addr_q;
    logic [7:0]       mem_q, wdata_q, rdata_q, tx_byte;
    logic             busy_q, done_q, ack_err_q;
    logic             sda_low, sda_low_n;
    logic             sda_in, tick, last_q, byte_end, tx_bit;

    assign sda_in   = sda;
    assign sda      = sda_low ? 1'b0 : 1'bz;
    assign tick     = (state != S_IDLE) && (qdiv == DIV_W'(CLK_DIV - 1));
    assign last_q   = tick && (q == 2'd3);
    assign byte_end = last_q && (bit_cnt == 3'd0);

    assign ctrl.rdata   = rdata_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.ack_err = ack_err_q;
    assign state_dbg    = state;

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_ADDR:  tx_byte = {addr_q, rw_q};
            S_MEM:   tx_byte = mem_q;
            S_WDATA: tx_byte = wdata_q;
            default: tx_byte = 8'h00;
        endcase
        tx_bit = tx_byte[bit_cnt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:          if (ctrl.start) state_n = S_START;
            S_START:         if (last_q)     state_n = S_ADDR;
            S_ADDR:          if (byte_end)   state_n = S_ACK_A;
            S_ACK_A:         if (last_q)     state_n = sda_in ? S_STOP : S_MEM;
            S_MEM:           if (byte_end)   state_n = S_ACK_M;
            S_ACK_M:         if (last_q)     state_n = sda_in ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
            S_WDATA:         if (byte_end)   state_n = S_ACK_W;
            S_RDATA:         if (byte_end)   state_n = S_MACK;
            S_ACK_W, S_MACK: if (last_q)     state_n = S_STOP;
            S_STOP:          if (last_q)     state_n = S_IDLE;
            default:                         state_n = S_IDLE;
        endcase
    end

    // SDA only moves at Q1 start, except START/STOP which move it while SCL is high.
    always_comb begin
        scl       = (state == S_IDLE || state == S_START) ? 1'b1 : q[1];
        sda_low_n = sda_low;
        if (state == S_IDLE) begin
            sda_low_n = 1'b0;
        end else if (state_n == S_STOP && state != S_STOP) begin
            sda_low_n = 1'b1;
        end else if (tick) begin
            case (state)
                S_START:                 if (q == 2'd0) sda_low_n = 1'b1;
                S_ADDR, S_MEM, S_WDATA:  if (q == 2'd0) sda_low_n = ~tx_bit;
                S_ACK_A, S_ACK_M, S_ACK_W,
                S_RDATA, S_MACK:         if (q == 2'd0) sda_low_n = 1'b0;
                S_STOP:                  if (q == 2'd2) sda_low_n = 1'b0;
                default:                 sda_low_n = sda_low;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qdiv      <= '0;
            q         <= 2'd0;
            bit_cnt   <= 3'd7;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            mem_q     <= 8'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            sda_low <= sda_low_n;
            done_q  <= 1'b0;
            if (state == S_IDLE) begin
                if (ctrl.start) begin
                    rw_q      <= ctrl.rw;
                    addr_q    <= ctrl.slave_addr;
                    mem_q     <= ctrl.mem_addr;
                    wdata_q   <= ctrl.wdata;
                    ack_err_q <= 1'b0;
                    busy_q    <= 1'b1;
                    qdiv      <= '0;
                    q         <= 2'd0;
                    bit_cnt   <= 3'd7;
                end
            end else begin
                qdiv <= tick ? '0 : qdiv + DIV_W'(1);
                if (tick) q <= q + 2'd1;
                if (last_q) begin
                    case (state)
                        S_ADDR, S_MEM, S_WDATA: bit_cnt <= bit_cnt - 3'd1;
                        S_RDATA: begin
                            bit_cnt <= bit_cnt - 3'd1;
                            rdata_q <= {rdata_q[6:0], sda_in};
                        end
                        S_ACK_A, S_ACK_M, S_ACK_W: if (sda_in) ack_err_q <= 1'b1;
                        S_STOP: begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a behavioural memory slave at address 7'h7F.
// Each request pushes {ack_err, rdata_valid, rdata, latency} and done pops it.
module tb_i2c_master_ctrl;

    localparam int         CLK_DIV  = 8;
    localparam logic [6:0] SLV_ADDR = 7'h7F;
    localparam int         W        = 26;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl;
    wire        sda;
    logic [3:0] state_dbg;

    i2c_master_ctrl_if ctrl_if();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (ctrl_if),
        .scl       (scl),
        .sda       (sda),
        .state_dbg (state_dbg)
    );

    pullup pu (sda);

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- slave model ----------------
    logic [7:0] slv_mem [8];
    bit         slv_ready = 1'b0;
    logic       scl_m = 1'b1, scl_q = 1'b1, scl_p = 1'b1;
    logic       sda_m = 1'b1, sda_q = 1'b1, sda_p = 1'b1;
    logic       s_oe = 1'b0;
    logic [3:0] oe_hist = 4'd0;
    logic       s_active = 1'b0, s_ack = 1'b0, s_rw = 1'b0;
    int         s_bit = 0, s_byte = 0;
    logic [7:0] s_sh = 8'd0, s_b, s_rd;
    logic [2:0] s_idx = 3'd0;
    logic       s_quiet;

    assign sda     = s_oe ? 1'b0 : 1'bz;
    assign s_quiet = (oe_hist == 4'd0) && !s_oe;

    always @(posedge clk) begin
        scl_m <= scl;  scl_q <= scl_m;  scl_p <= scl_q;
        sda_m <= sda;  sda_q <= sda_m;  sda_p <= sda_q;
        oe_hist <= {oe_hist[2:0], s_oe};
        if (!slv_ready) begin
            for (int i = 0; i < 8; i++) slv_mem[i] <= 8'h10 + 8'(i);
            slv_ready <= 1'b1;
        end
        if (s_quiet && scl_q && scl_p && sda_p && !sda_q) begin
            s_active <= 1'b1;  s_bit <= 0;  s_byte <= 0;  s_ack <= 1'b0;
        end else if (s_quiet && scl_q && scl_p && !sda_p && sda_q) begin
            s_active <= 1'b0;
        end else if (!scl_q && scl_p) begin
            s_oe <= 1'b0;
        end else if (s_active && scl_q && !scl_p) begin
            if (s_bit < 8) begin
                s_bit <= s_bit + 1;
                if (s_byte == 2 && s_rw) begin
                    s_rd = slv_mem[s_idx];
                    s_oe <= ~s_rd[7 - s_bit];
                end else begin
                    s_sh <= {s_sh[6:0], sda_q};
                    if (s_bit == 7) begin
                        s_b = {s_sh[6:0], sda_q};
                        case (s_byte)
                            0: begin s_ack <= (s_b[7:1] == SLV_ADDR); s_rw <= s_b[0]; end
                            1: begin s_ack <= (s_b < 8'd8); s_idx <= s_b[2:0]; end
                            default: begin s_ack <= 1'b1; slv_mem[s_idx] <= s_b; end
                        endcase
                    end
                end
            end else begin
                s_bit  <= 0;
                s_byte <= s_byte + 1;
                if (s_byte == 2 && s_rw) begin
                    s_active <= 1'b0;
                end else begin
                    s_oe <= s_ack;
                    if (!s_ack) s_active <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   model_mem [8];
    int n_checks = 0, n_err = 0;
    int done_cnt = 0, stop_cnt = 0, t_busy = 0;
    logic busy_prev = 1'b0, sda_pn = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            if (ctrl_if.busy && !busy_prev) t_busy = cyc;
            if (scl && !sda_pn && sda) stop_cnt++;
            if (ctrl_if.done) begin
                done_cnt++;
                check("busy_low_at_done", ctrl_if.busy, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_err", ctrl_if.ack_err, e[25]);
                    if (e[24]) check("rdata", ctrl_if.rdata, e[23:16]);
                    check("latency", cyc - t_busy, e[15:0]);
                end
            end
        end
        busy_prev = ctrl_if.busy;
        sda_pn    = sda;
    end

    // ---------------- driver tasks ----------------
    // Caller is just after a posedge with the DUT idle.
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] m, input logic [7:0] d);
        logic ok_a, ok_m, err, chk;
        logic [15:0] lat;
        logic [7:0]  rexp;
        ok_a = (a == SLV_ADDR);
        ok_m = (m < 8'd8);
        if (!ok_a)      begin lat = 16'(44 * CLK_DIV);  err = 1'b1; end
        else if (!ok_m) begin lat = 16'(80 * CLK_DIV);  err = 1'b1; end
        else            begin lat = 16'(116 * CLK_DIV); err = 1'b0; end
        chk  = ok_a && ok_m && r;
        rexp = chk ? model_mem[m[2:0]] : 8'h00;
        if (ok_a && ok_m && !r) model_mem[m[2:0]] = d;
        exp_q.push_back({err, chk, rexp, lat});
        ctrl_if.rw = r;  ctrl_if.slave_addr = a;  ctrl_if.mem_addr = m;  ctrl_if.wdata = d;
        ctrl_if.start = 1'b1;
        @(posedge clk); #1;
        ctrl_if.start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt <= n0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check("done_seen", done_cnt > n0, 1);
    endtask

    task automatic txn(input logic r, input logic [6:0] a, input logic [7:0] m, input logic [7:0] d);
        int n0;
        n0 = done_cnt;
        @(posedge clk); #1;
        issue(r, a, m, d);
        wait_done(n0);
        repeat (3) @(posedge clk);
        #1;
        check("scl_idle", scl, 1);
        check("sda_idle", sda, 1);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 8; i++) check($sformatf("mem%0d", i), slv_mem[i], model_mem[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0, s0, k;
        logic [7:0] saved;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h10 + 8'(i);
        ctrl_if.start = 1'b0;  ctrl_if.rw = 1'b0;  ctrl_if.slave_addr = 7'd0;
        ctrl_if.mem_addr = 8'd0;  ctrl_if.wdata = 8'd0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", ctrl_if.busy, 0);
        check("rst_done", ctrl_if.done, 0);
        check("rst_ack_err", ctrl_if.ack_err, 0);
        check("rst_rdata", ctrl_if.rdata, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // write with a second start while busy
        n0 = done_cnt;
        @(posedge clk); #1;
        issue(1'b0, SLV_ADDR, 8'd3, 8'hA5);
        repeat (200) @(posedge clk);
        #1;
        ctrl_if.start = 1'b1;  ctrl_if.rw = 1'b1;  ctrl_if.slave_addr = 7'h12;
        @(posedge clk); #1;
        ctrl_if.start = 1'b0;
        wait_done(n0);
        repeat (300) @(posedge clk);
        #1;
        check("single_done", done_cnt - n0, 1);
        check("mem3_written", slv_mem[3], 8'hA5);

        // read back with STOP observation
        s0 = stop_cnt;
        txn(1'b1, SLV_ADDR, 8'd3, 8'h00);
        check("stop_seen", stop_cnt - s0, 1);

        // wrong slave address, then out-of-range index
        txn(1'b0, 7'h12, 8'd3, 8'h77);
        txn(1'b0, SLV_ADDR, 8'd9, 8'h5A);
        check_mem();

        // reset during mem_addr bits
        saved = model_mem[5];
        @(posedge clk); #1;
        issue(1'b0, SLV_ADDR, 8'd5, 8'hC3);
        repeat (360) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        check("abort_busy", ctrl_if.busy, 0);
        check("abort_rdata", ctrl_if.rdata, 0);
        void'(exp_q.pop_back());
        model_mem[5] = saved;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);

        // back-to-back: second start in the cycle after done
        n0 = done_cnt;
        @(posedge clk); #1;
        issue(1'b0, SLV_ADDR, 8'd1, 8'h3C);
        k = 0;
        while (!ctrl_if.done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        issue(1'b1, SLV_ADDR, 8'd1, 8'h00);
        wait_done(n0 + 1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_done_count", done_cnt - n0, 2);

        // random mix
        for (int i = 0; i < 5; i++) begin
            logic r;
            logic [6:0] a;
            logic [7:0] m, d;
            r = 1'($urandom_range(0, 1));
            m = 8'($urandom_range(0, 9));
            a = ($urandom_range(0, 4) == 0) ? 7'h12 : SLV_ADDR;
            d = 8'($urandom_range(0, 255));
            txn(r, a, m, d);
        end
        check_mem();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
